// File: rtl/spoc_perm_sched.sv
// Round scheduler for the SpoC-64 permutation: sequences rounds, steps and the round-constant LFSR.
// Optional feature: define SPOC_PERM_2X_EN for two rounds per cycle (RPS must be even).
module spoc_perm_sched #(
  parameter int unsigned STEPS   = 18,
  parameter int unsigned RPS     = 6,
  parameter logic [5:0]  RC_SEED = 6'b111111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       en_round,
  output logic       en_step,
  output logic [5:0] rc,
  output logic [5:0] rc_nxt,
  output logic [4:0] step_ctr,
  output logic [2:0] round_ctr,
  output logic       perm_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [5:0] lfsr_f(input logic [5:0] x);
    return {x[4:0], x[5] ^ x[4]};
  endfunction

  state_t     state_q, state_d;
  logic [5:0] lfsr_q, lfsr_d;
  logic [4:0] step_q, step_d;
  logic [2:0] round_q, round_d;

  logic       run;
  logic [5:0] lfsr_step1;
  logic [5:0] lfsr_adv;
  logic [3:0] round_sum;
  logic       step_hit;

`ifdef SPOC_PERM_2X_EN
  localparam logic [3:0] R_INC = 4'd2;

  if ((RPS % 2) != 0) begin : g_rps_odd
    $error("spoc_perm_sched: RPS must be even when SPOC_PERM_2X_EN is defined");
  end

  assign lfsr_step1 = lfsr_f(lfsr_q);
  assign lfsr_adv   = lfsr_f(lfsr_step1);
  assign rc_nxt     = run ? lfsr_step1 : 6'd0;
`else
  localparam logic [3:0] R_INC = 4'd1;

  assign lfsr_step1 = lfsr_f(lfsr_q);
  assign lfsr_adv   = lfsr_step1;
  assign rc_nxt     = 6'd0;
`endif

  localparam logic [3:0] RPS_W     = 4'(RPS);
  localparam logic [4:0] LAST_STEP = 5'(STEPS - 1);

  assign run       = (state_q == RUN);
  assign round_sum = {1'b0, round_q} + R_INC;
  assign step_hit  = run && (round_sum == RPS_W);

  // Outputs decode registered state only; start never reaches them combinationally.
  assign busy      = run;
  assign en_round  = run;
  assign en_step   = step_hit;
  assign rc        = run ? lfsr_q : 6'd0;
  assign step_ctr  = step_q;
  assign round_ctr = round_q;
  assign perm_done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    step_d  = step_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          lfsr_d  = RC_SEED;
          step_d  = 5'd0;
          round_d = 3'd0;
        end
      end
      RUN: begin
        lfsr_d = lfsr_adv;
        if (step_hit) begin
          round_d = 3'd0;
          step_d  = step_q + 5'd1;
          if (step_q == LAST_STEP) begin
            state_d = DONE;
          end
        end else begin
          round_d = round_sum[2:0];
        end
      end
      DONE: begin
        // A start in the completion cycle chains straight into the next permutation.
        if (start) begin
          state_d = RUN;
          lfsr_d  = RC_SEED;
          step_d  = 5'd0;
          round_d = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= RC_SEED;
      step_q  <= 5'd0;
      round_q <= 3'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      step_q  <= step_d;
      round_q <= round_d;
    end
  end

endmodule

// File: tb/tb_spoc_perm_sched.sv
// Directed self-checking bench for spoc_perm_sched (default parameters plus a STEPS=1/RPS=1 corner).
module tb_spoc_perm_sched;

`ifdef SPOC_PERM_2X_EN
  localparam int R = 2;
`else
  localparam int R = 1;
`endif
  localparam int STEPS = 18;
  localparam int RPS   = 6;
  localparam int N     = STEPS * RPS / R;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, en_round, en_step, perm_done;
  logic [5:0] rc, rc_nxt;
  logic [4:0] step_ctr;
  logic [2:0] round_ctr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spoc_perm_sched #(.STEPS(STEPS), .RPS(RPS), .RC_SEED(6'h3F)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .en_round(en_round),
    .en_step(en_step), .rc(rc), .rc_nxt(rc_nxt), .step_ctr(step_ctr),
    .round_ctr(round_ctr), .perm_done(perm_done)
  );

`ifndef SPOC_PERM_2X_EN
  logic       c_start = 1'b0;
  logic       c_busy, c_en_round, c_en_step, c_perm_done;
  logic [5:0] c_rc, c_rc_nxt;
  logic [4:0] c_step_ctr;
  logic [2:0] c_round_ctr;

  spoc_perm_sched #(.STEPS(1), .RPS(1), .RC_SEED(6'h3F)) dut_corner (
    .clk(clk), .rst(rst), .start(c_start), .busy(c_busy), .en_round(c_en_round),
    .en_step(c_en_step), .rc(c_rc), .rc_nxt(c_rc_nxt), .step_ctr(c_step_ctr),
    .round_ctr(c_round_ctr), .perm_done(c_perm_done)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] lf(input logic [5:0] x);
    return {x[4:0], x[5] ^ x[4]};
  endfunction

  // Called at a negedge; returns at the negedge of the first RUN cycle.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Walks one permutation from its first RUN cycle up to the perm_done cycle.
  task automatic run_body(input string tag, input bit mid_start, input bit chain_next);
    logic [5:0] m;
    logic [5:0] first_rc [7];
    int k;
    int steps_seen;
    first_rc = '{6'h3F, 6'h3E, 6'h3C, 6'h38, 6'h30, 6'h20, 6'h01};
    m = 6'h3F;
    k = 0;
    steps_seen = 0;
    while (en_round === 1'b1 && k < 300) begin
      check({tag, ":busy"}, 32'(busy), 32'd1);
      check({tag, ":rc"}, 32'(rc), 32'(m));
      check({tag, ":rc_nxt"}, 32'(rc_nxt), (R == 2) ? 32'(lf(m)) : 32'd0);
      check({tag, ":round_ctr"}, 32'(round_ctr), 32'((k * R) % RPS));
      check({tag, ":step_ctr"}, 32'(step_ctr), 32'((k * R) / RPS));
      check({tag, ":en_step"}, 32'(en_step), 32'(((k * R + R) % RPS) == 0));
      if (R == 1 && k < 7) check({tag, ":rc_seq"}, 32'(rc), 32'(first_rc[k]));
      if (R == 2 && k < 3) check({tag, ":rc_seq2"}, 32'(rc_nxt), 32'(first_rc[2 * k + 1]));
      if (R == 1 && k == 63) check({tag, ":rc_r64"}, 32'(rc), 32'h3F);
      if (R == 2 && k == 31) check({tag, ":rc_r64"}, 32'(rc_nxt), 32'h3F);
      if (k == N - 1) check({tag, ":last_step"}, 32'(step_ctr), 32'(STEPS - 1));
      if (en_step === 1'b1) steps_seen++;
      start = mid_start && (k == 20);
      for (int i = 0; i < R; i++) m = lf(m);
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, ":en_round_len"}, 32'(k), 32'(N));
    check({tag, ":step_count"}, 32'(steps_seen), 32'(STEPS));
    check({tag, ":perm_done"}, 32'(perm_done), 32'd1);
    check({tag, ":done_busy"}, 32'(busy), 32'd0);
    check({tag, ":done_en_step"}, 32'(en_step), 32'd0);
    start = chain_next;
    @(negedge clk);
    start = 1'b0;
    check({tag, ":after_done"}, 32'(perm_done), 32'd0);
    check({tag, ":after_busy"}, 32'(busy), 32'(chain_next));
    $display("txn %s: %0d round cycles, %0d steps", tag, k, steps_seen);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:en_round", 32'(en_round), 32'd0);
    check("rst:en_step", 32'(en_step), 32'd0);
    check("rst:rc", 32'(rc), 32'd0);
    check("rst:rc_nxt", 32'(rc_nxt), 32'd0);
    check("rst:step_ctr", 32'(step_ctr), 32'd0);
    check("rst:round_ctr", 32'(round_ctr), 32'd0);
    check("rst:perm_done", 32'(perm_done), 32'd0);
    $display("txn reset: outputs checked");
    @(negedge clk);

    // Single permutation
    pulse_start();
    run_body("single", 1'b0, 1'b0);

    // Back-to-back: start in perm_done cycle, plus an ignored start mid-run
    @(negedge clk);
    pulse_start();
    run_body("b2b_a", 1'b0, 1'b1);
    run_body("b2b_b", 1'b1, 1'b0);

    // Reset in the middle of a run (round 50 executes in cycle index 49)
    @(negedge clk);
    pulse_start();
    repeat (49) @(negedge clk);
    check("midrst:running", 32'(en_round), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst:busy", 32'(busy), 32'd0);
    check("midrst:en_round", 32'(en_round), 32'd0);
    check("midrst:rc", 32'(rc), 32'd0);
    check("midrst:step_ctr", 32'(step_ctr), 32'd0);
    check("midrst:round_ctr", 32'(round_ctr), 32'd0);
    check("midrst:perm_done", 32'(perm_done), 32'd0);
    @(negedge clk);
    check("midrst:no_done", 32'(perm_done), 32'd0);
    $display("txn midrst: reset applied at round 50");
    pulse_start();
    run_body("post_rst", 1'b0, 1'b0);

    // rst and start together: rst wins
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("rst_start:busy", 32'(busy), 32'd0);
    $display("txn rst_start: simultaneous rst/start");

`ifndef SPOC_PERM_2X_EN
    @(negedge clk);
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    check("corner:en_round", 32'(c_en_round), 32'd1);
    check("corner:en_step", 32'(c_en_step), 32'd1);
    check("corner:rc", 32'(c_rc), 32'h3F);
    check("corner:done_early", 32'(c_perm_done), 32'd0);
    @(negedge clk);
    check("corner:perm_done", 32'(c_perm_done), 32'd1);
    check("corner:en_round_off", 32'(c_en_round), 32'd0);
    @(negedge clk);
    check("corner:done_off", 32'(c_perm_done), 32'd0);
    check("corner:idle_busy", 32'(c_busy), 32'd0);
    $display("txn corner: STEPS=1 RPS=1");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
